// File: rtl/z80_store_seq.sv
// Z80 store sequencer: runs LD (BC),A / LD (DE),A / LD (HL),r / LD (nn),A after M1.
// Latency: start cycle + (3+w) per memory cycle + 1 DONE cycle; illegal opcodes finish in 2 cycles.
// Backpressure: bus_wait stretches each memory cycle with Tw states; start is ignored while busy.
//
// Ports:
//   clk, reset                  one clock per T-state; asynchronous active-high reset
//   start, opcode, ip_in        request, fetched opcode, opcode address (latched on accept)
//   reg_a, reg_bc, reg_de,
//   reg_hl, reg_src             register file values (latched on accept)
//   bus_rdata, bus_wait         memory read data and external wait request
//   bus_addr, bus_wdata,
//   bus_mreq, bus_rd, bus_wr    registered bus address, data and strobes
//   busy, done, err             activity flag, completion pulse, illegal-opcode qualifier
//   ip_out, mcycles, tcycles    next IP, M-cycle count, saturating T-state count (valid with done)
module z80_store_seq #(
   parameter int unsigned WAIT_STATES = 0,
   parameter bit          ENABLE_NN   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  opcode,
   input  logic [15:0] ip_in,
   input  logic [7:0]  reg_a,
   input  logic [15:0] reg_bc,
   input  logic [15:0] reg_de,
   input  logic [15:0] reg_hl,
   input  logic [7:0]  reg_src,
   input  logic [7:0]  bus_rdata,
   input  logic        bus_wait,
   output logic        busy,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_mreq,
   output logic        bus_rd,
   output logic        bus_wr,
   output logic        done,
   output logic        err,
   output logic [15:0] ip_out,
   output logic [2:0]  mcycles,
   output logic [5:0]  tcycles
);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR, DONE} state_t;
   typedef enum logic [1:0] {T1, T2, TW, T3} phase_t;

   localparam logic [4:0] WS = 5'(WAIT_STATES);

   state_t      state_q, state_d;
   phase_t      phase_q, phase_d;
   logic [3:0]  wcnt_q, wcnt_d;       // Tw states elapsed in the current memory cycle
   logic [4:0]  wcnt_inc;
   logic [15:0] ip_q, ip_d;
   logic [7:0]  a_q, a_d;
   logic [15:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic [7:0]  lo_q, lo_d;
   logic        nn_q, nn_d;           // current instruction is LD (nn),A
   logic        bad_q, bad_d;         // illegal opcode
   logic [2:0]  mcyc_q, mcyc_d;
   logic [5:0]  tcyc_q, tcyc_d;

   // next values of the registered outputs
   logic        busy_d, mreq_d, rd_d, wr_d, done_d, err_d, fin_d;
   logic [15:0] addr_d, ip_out_d;
   logic [7:0]  wdata_d;
   logic [2:0]  mcycles_d;
   logic [5:0]  tcycles_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         phase_q   <= T1;
         wcnt_q    <= '0;
         ip_q      <= '0;
         a_q       <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         lo_q      <= '0;
         nn_q      <= 1'b0;
         bad_q     <= 1'b0;
         mcyc_q    <= '0;
         tcyc_q    <= '0;
         busy      <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_mreq  <= 1'b0;
         bus_rd    <= 1'b0;
         bus_wr    <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         ip_out    <= '0;
         mcycles   <= '0;
         tcycles   <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         wcnt_q    <= wcnt_d;
         ip_q      <= ip_d;
         a_q       <= a_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         lo_q      <= lo_d;
         nn_q      <= nn_d;
         bad_q     <= bad_d;
         mcyc_q    <= mcyc_d;
         tcyc_q    <= tcyc_d;
         busy      <= busy_d;
         bus_addr  <= addr_d;
         bus_wdata <= wdata_d;
         bus_mreq  <= mreq_d;
         bus_rd    <= rd_d;
         bus_wr    <= wr_d;
         done      <= done_d;
         err       <= err_d;
         ip_out    <= ip_out_d;
         mcycles   <= mcycles_d;
         tcycles   <= tcycles_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      wcnt_d    = wcnt_q;
      ip_d      = ip_q;
      a_d       = a_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      lo_d      = lo_q;
      nn_d      = nn_q;
      bad_d     = bad_q;
      mcyc_d    = mcyc_q;
      tcyc_d    = tcyc_q;
      wcnt_inc  = {1'b0, wcnt_q} + 5'd1;

      case (state_q)
         IDLE: begin
            if (start) begin
               ip_d    = ip_in;
               a_d     = reg_a;
               nn_d    = 1'b0;
               bad_d   = 1'b0;
               mcyc_d  = 3'd1;
               tcyc_d  = 6'd4;        // M1 already spent 4 T-states
               phase_d = T1;
               wcnt_d  = '0;
               case (opcode)
                  8'h02: begin wr_addr_d = reg_bc; wr_data_d = reg_a; state_d = WR; end
                  8'h12: begin wr_addr_d = reg_de; wr_data_d = reg_a; state_d = WR; end
                  8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h77: begin
                     wr_addr_d = reg_hl;
                     wr_data_d = reg_src;
                     state_d   = WR;
                  end
                  8'h32: begin
                     if (ENABLE_NN) begin
                        nn_d    = 1'b1;
                        state_d = RD_LO;
                     end else begin
                        bad_d   = 1'b1;
                        state_d = DONE;
                     end
                  end
                  default: begin
                     bad_d   = 1'b1;
                     state_d = DONE;
                  end
               endcase
            end
         end
         RD_LO, RD_HI, WR: begin
            // every T-state of a memory cycle (T1, T2, Tw, T3) adds one
            tcyc_d = (tcyc_q == 6'd63) ? tcyc_q : tcyc_q + 6'd1;
            case (phase_q)
               T1: phase_d = T2;
               T2: begin
                  wcnt_d  = '0;
                  phase_d = ((WS != 5'd0) || bus_wait) ? TW : T3;
               end
               TW: begin
                  wcnt_d  = (wcnt_q == 4'hF) ? wcnt_q : wcnt_q + 4'd1;
                  phase_d = ((wcnt_inc < WS) || bus_wait) ? TW : T3;
               end
               default: begin         // T3: cycle ends on this edge
                  phase_d = T1;
                  mcyc_d  = mcyc_q + 3'd1;
                  if (state_q == RD_LO) begin
                     lo_d    = bus_rdata;
                     state_d = RD_HI;
                  end else if (state_q == RD_HI) begin
                     wr_addr_d = {bus_rdata, lo_q};
                     wr_data_d = a_q;
                     state_d   = WR;
                  end else begin
                     state_d = DONE;
                  end
               end
            endcase
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // outputs are registered, so they are derived from the next state
      busy_d = (state_d != IDLE);
      mreq_d = (state_d == RD_LO) || (state_d == RD_HI) || (state_d == WR);
      rd_d   = (state_d == RD_LO) || (state_d == RD_HI);
      wr_d   = (state_d == WR) && (phase_d != T1);
      done_d = (state_d == DONE);
      err_d  = (state_d == DONE) && bad_d;
      fin_d  = (state_d == DONE) && (state_q != DONE);

      addr_d = bus_addr;
      case (state_d)
         RD_LO:   addr_d = ip_d + 16'd1;
         RD_HI:   addr_d = ip_d + 16'd2;
         WR:      addr_d = wr_addr_d;
         default: addr_d = bus_addr;
      endcase
      wdata_d = (state_d == WR) ? wr_data_d : bus_wdata;

      ip_out_d  = fin_d ? (ip_d + (nn_d ? 16'd3 : 16'd1)) : ip_out;
      mcycles_d = fin_d ? mcyc_d : mcycles;
      tcycles_d = fin_d ? tcyc_d : tcycles;
   end

endmodule

// File: tb/tb_z80_store_seq.sv
module tb_z80_store_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, sel, bus_wait;
   logic [7:0]  opcode, reg_a, reg_src, bus_rdata;
   logic [15:0] ip_in, reg_bc, reg_de, reg_hl;
   logic        start0, start1;
   assign start0 = start & ~sel;
   assign start1 = start & sel;

   logic        busy0, mreq0, rd0, wr0, done0, err0;
   logic [15:0] addr0, ipo0;
   logic [7:0]  wdata0;
   logic [2:0]  mc0;
   logic [5:0]  tc0;
   logic        busy1, mreq1, rd1, wr1, done1, err1;
   logic [15:0] addr1, ipo1;
   logic [7:0]  wdata1;
   logic [2:0]  mc1;
   logic [5:0]  tc1;

   z80_store_seq #(.WAIT_STATES(0), .ENABLE_NN(1'b1)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .opcode(opcode), .ip_in(ip_in),
      .reg_a(reg_a), .reg_bc(reg_bc), .reg_de(reg_de), .reg_hl(reg_hl), .reg_src(reg_src),
      .bus_rdata(bus_rdata), .bus_wait(bus_wait), .busy(busy0), .bus_addr(addr0),
      .bus_wdata(wdata0), .bus_mreq(mreq0), .bus_rd(rd0), .bus_wr(wr0), .done(done0),
      .err(err0), .ip_out(ipo0), .mcycles(mc0), .tcycles(tc0));

   z80_store_seq #(.WAIT_STATES(2), .ENABLE_NN(1'b0)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .opcode(opcode), .ip_in(ip_in),
      .reg_a(reg_a), .reg_bc(reg_bc), .reg_de(reg_de), .reg_hl(reg_hl), .reg_src(reg_src),
      .bus_rdata(bus_rdata), .bus_wait(bus_wait), .busy(busy1), .bus_addr(addr1),
      .bus_wdata(wdata1), .bus_mreq(mreq1), .bus_rd(rd1), .bus_wr(wr1), .done(done1),
      .err(err1), .ip_out(ipo1), .mcycles(mc1), .tcycles(tc1));

   // view of whichever instance is under test
   logic        m_busy, m_mreq, m_rd, m_wr, m_done, m_err;
   logic [15:0] m_addr, m_ipo;
   logic [7:0]  m_wdata;
   logic [2:0]  m_mc;
   logic [5:0]  m_tc;
   assign m_busy  = sel ? busy1  : busy0;
   assign m_mreq  = sel ? mreq1  : mreq0;
   assign m_rd    = sel ? rd1    : rd0;
   assign m_wr    = sel ? wr1    : wr0;
   assign m_done  = sel ? done1  : done0;
   assign m_err   = sel ? err1   : err0;
   assign m_addr  = sel ? addr1  : addr0;
   assign m_ipo   = sel ? ipo1   : ipo0;
   assign m_wdata = sel ? wdata1 : wdata0;
   assign m_mc    = sel ? mc1    : mc0;
   assign m_tc    = sel ? tc1    : tc0;

   typedef struct {logic err; logic [15:0] ip; logic [2:0] mc; logic [5:0] tc;} exp_t;
   typedef struct {logic [15:0] addr; logic [7:0] data;} wr_t;

   exp_t        exp_q[$];
   wr_t         exp_wr[$];
   wr_t         act_wr[$];
   logic [15:0] act_rd[$];
   logic [7:0]  mem [65536];

   int n_chk = 0, n_pass = 0;
   int cyc, done_cyc, wr_cycles, mreq_cycles, strobe_err, stab_err, overlap_err;
   int wait_from = 1000, wait_to = 0;
   bit got_done;
   logic        d_err;
   logic [15:0] d_ip;
   logic [2:0]  d_mc;
   logic [5:0]  d_tc;

   // Drives one operation on the selected instance and records what appears on its bus.
   task automatic run_op(input bit issue, input bit hold, input int budget);
      bit          seg_on = 1'b0, seg_rd = 1'b0, seg_wr = 1'b0;
      logic [15:0] seg_addr = '0;
      logic [7:0]  seg_wdata = '0;
      act_wr.delete(); act_rd.delete();
      wr_cycles = 0; mreq_cycles = 0; strobe_err = 0; stab_err = 0; overlap_err = 0;
      got_done = 1'b0; cyc = 0; done_cyc = -1;
      if (issue) start = 1'b1;
      while (!got_done && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (!hold) begin
            start = 1'b0;
            if (cyc == 1) begin      // scramble inputs: the DUT must use latched copies
               opcode = 8'($urandom); ip_in = 16'($urandom); reg_a = 8'($urandom);
               reg_bc = 16'($urandom); reg_de = 16'($urandom); reg_hl = 16'($urandom);
               reg_src = 8'($urandom);
            end
         end
         if (m_mreq) begin
            mreq_cycles++;
            if (!seg_on || m_addr != seg_addr || m_rd != seg_rd) begin
               seg_on = 1'b1; seg_addr = m_addr; seg_rd = m_rd; seg_wdata = m_wdata; seg_wr = 1'b0;
               if (m_rd) act_rd.push_back(m_addr);
               else      act_wr.push_back('{m_addr, m_wdata});
            end else begin
               if (!m_rd && m_wdata != seg_wdata) stab_err++;
               if (seg_wr && !m_wr) stab_err++;
            end
            if (m_wr) begin seg_wr = 1'b1; wr_cycles++; end
            if (!m_busy) strobe_err++;
         end else begin
            seg_on = 1'b0;
            if (m_rd || m_wr) strobe_err++;
         end
         if (m_rd && m_wr) overlap_err++;
         bus_rdata = m_rd ? mem[m_addr] : 8'h00;
         bus_wait  = (cyc >= wait_from && cyc <= wait_to);
         if (m_done) begin
            got_done = 1'b1; done_cyc = cyc;
            d_err = m_err; d_ip = m_ipo; d_mc = m_mc; d_tc = m_tc;
         end
      end
      bus_wait = 1'b0;
   endtask

   task automatic test_reset();
      n_chk++;
      if ({busy0, done0, err0, mreq0, rd0, wr0} !== 6'b0) $display("FAIL reset_flags: got %b want 000000", {busy0, done0, err0, mreq0, rd0, wr0});
      else n_pass++;
      n_chk++;
      if ({addr0, wdata0, ipo0, mc0, tc0} !== 49'b0) $display("FAIL reset_values: got %h want 0", {addr0, wdata0, ipo0, mc0, tc0});
      else n_pass++;
      n_chk++;
      if ({busy1, mreq1, done1} !== 3'b0) $display("FAIL reset_dut1: got %b want 000", {busy1, mreq1, done1});
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_store_de();
      exp_t e; wr_t w;
      @(negedge clk);
      sel = 1'b0; opcode = 8'h12; reg_de = 16'h4000; reg_a = 8'h5A; ip_in = 16'h1000;
      exp_q.push_back('{1'b0, 16'h1001, 3'd2, 6'd7});
      exp_wr.push_back('{16'h4000, 8'h5A});
      run_op(1'b1, 1'b0, 20);
      n_chk++;
      if (!got_done || done_cyc != 4) $display("FAIL de_latency: got done=%0d at %0d want at 4", got_done, done_cyc);
      else n_pass++;
      e = exp_q.pop_front();
      n_chk++;
      if ({d_err, d_ip, d_mc, d_tc} !== {e.err, e.ip, e.mc, e.tc}) $display("FAIL de_done_fields: got %h want %h", {d_err, d_ip, d_mc, d_tc}, {e.err, e.ip, e.mc, e.tc});
      else n_pass++;
      w = exp_wr.pop_front();
      n_chk++;
      if (act_wr.size() != 1 || act_wr[0] != w) $display("FAIL de_write: got %0d writes first %h/%h want 1 of %h/%h", act_wr.size(), (act_wr.size() > 0) ? act_wr[0].addr : 16'h0, (act_wr.size() > 0) ? act_wr[0].data : 8'h0, w.addr, w.data);
      else n_pass++;
      n_chk++;
      if (wr_cycles != 2 || act_rd.size() != 0) $display("FAIL de_wr_cycles: got wr=%0d rd=%0d want wr=2 rd=0", wr_cycles, act_rd.size());
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (m_done !== 1'b0 || m_busy !== 1'b0) $display("FAIL de_done_pulse: got done=%b busy=%b want 0 0", m_done, m_busy);
      else n_pass++;
   endtask

   task automatic test_store_nn();
      exp_t e; wr_t w;
      @(negedge clk);
      sel = 1'b0; opcode = 8'h32; ip_in = 16'hFFFE; reg_a = 8'hC3;
      mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
      exp_q.push_back('{1'b0, 16'h0001, 3'd4, 6'd13});
      exp_wr.push_back('{16'h1234, 8'hC3});
      run_op(1'b1, 1'b0, 30);
      n_chk++;
      if (!got_done || done_cyc != 10) $display("FAIL nn_latency: got done=%0d at %0d want at 10", got_done, done_cyc);
      else n_pass++;
      e = exp_q.pop_front();
      n_chk++;
      if ({d_err, d_ip, d_mc, d_tc} !== {e.err, e.ip, e.mc, e.tc}) $display("FAIL nn_done_fields: got %h want %h", {d_err, d_ip, d_mc, d_tc}, {e.err, e.ip, e.mc, e.tc});
      else n_pass++;
      n_chk++;
      if (act_rd.size() != 2 || act_rd[0] !== 16'hFFFF || act_rd[1] !== 16'h0000) $display("FAIL nn_reads: got %0d reads want FFFF then 0000", act_rd.size());
      else n_pass++;
      w = exp_wr.pop_front();
      n_chk++;
      if (act_wr.size() != 1 || act_wr[0] != w) $display("FAIL nn_write: got %0d writes first %h/%h want 1 of %h/%h", act_wr.size(), (act_wr.size() > 0) ? act_wr[0].addr : 16'h0, (act_wr.size() > 0) ? act_wr[0].data : 8'h0, w.addr, w.data);
      else n_pass++;
      n_chk++;
      if (overlap_err != 0 || strobe_err != 0) $display("FAIL nn_strobes: got overlap=%0d stray=%0d want 0 0", overlap_err, strobe_err);
      else n_pass++;
   endtask

   task automatic test_wait_states();
      exp_t e; wr_t w;
      @(negedge clk);
      sel = 1'b1; opcode = 8'h02; reg_bc = 16'h2468; reg_a = 8'h99; ip_in = 16'h0100;
      wait_from = 4; wait_to = 6;      // bus_wait high in Tw2..Tw4: 2 fixed + 3 extra Tw
      exp_q.push_back('{1'b0, 16'h0101, 3'd2, 6'd12});
      exp_wr.push_back('{16'h2468, 8'h99});
      run_op(1'b1, 1'b0, 30);
      wait_from = 1000; wait_to = 0;
      n_chk++;
      if (!got_done || done_cyc != 9) $display("FAIL ws_latency: got done=%0d at %0d want at 9", got_done, done_cyc);
      else n_pass++;
      e = exp_q.pop_front();
      n_chk++;
      if ({d_err, d_ip, d_mc, d_tc} !== {e.err, e.ip, e.mc, e.tc}) $display("FAIL ws_done_fields: got %h want %h", {d_err, d_ip, d_mc, d_tc}, {e.err, e.ip, e.mc, e.tc});
      else n_pass++;
      w = exp_wr.pop_front();
      n_chk++;
      if (act_wr.size() != 1 || act_wr[0] != w) $display("FAIL ws_write: got %0d writes want 1 of %h/%h", act_wr.size(), w.addr, w.data);
      else n_pass++;
      n_chk++;
      if (wr_cycles != 7 || mreq_cycles != 8 || stab_err != 0) $display("FAIL ws_stable: got wr=%0d mreq=%0d unstable=%0d want 7 8 0", wr_cycles, mreq_cycles, stab_err);
      else n_pass++;
   endtask

   task automatic test_illegal();
      bit   sels[3] = '{1'b0, 1'b0, 1'b1};
      logic [7:0] ops[3] = '{8'h76, 8'h00, 8'h32};
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         sel = sels[i]; opcode = ops[i]; ip_in = 16'hFFFF - 16'(i);
         exp_q.push_back('{1'b1, 16'hFFFF - 16'(i) + 16'd1, 3'd1, 6'd4});
         run_op(1'b1, 1'b0, 10);
         e = exp_q.pop_front();
         n_chk++;
         if (!got_done || done_cyc != 1) $display("FAIL ill_latency op=%h: got done=%0d at %0d want at 1", ops[i], got_done, done_cyc);
         else n_pass++;
         n_chk++;
         if ({d_err, d_ip, d_mc, d_tc} !== {e.err, e.ip, e.mc, e.tc}) $display("FAIL ill_done_fields op=%h: got %h want %h", ops[i], {d_err, d_ip, d_mc, d_tc}, {e.err, e.ip, e.mc, e.tc});
         else n_pass++;
         n_chk++;
         if (mreq_cycles != 0 || strobe_err != 0) $display("FAIL ill_no_bus op=%h: got mreq=%0d stray=%0d want 0 0", ops[i], mreq_cycles, strobe_err);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e; wr_t w;
      int n_done = 0;
      @(negedge clk);
      sel = 1'b0; opcode = 8'h12; reg_de = 16'h5555; reg_a = 8'h66; ip_in = 16'h0300;
      start = 1'b1;
      @(negedge clk); start = 1'b0;    // T1
      @(negedge clk);                  // T2
      n_chk++;
      if (m_wr !== 1'b1) $display("FAIL rst_in_t2: got wr=%b want 1", m_wr);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_chk++;
      if ({m_mreq, m_rd, m_wr, m_busy} !== 4'b0) $display("FAIL rst_async: got %b want 0000", {m_mreq, m_rd, m_wr, m_busy});
      else n_pass++;
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (m_done || m_busy || m_mreq) n_done++;
      end
      n_chk++;
      if (n_done != 0) $display("FAIL rst_quiet: got %0d active cycles want 0", n_done);
      else n_pass++;
      opcode = 8'h77; reg_hl = 16'h1357; reg_src = 8'hAB; ip_in = 16'h0400;
      exp_q.push_back('{1'b0, 16'h0401, 3'd2, 6'd7});
      exp_wr.push_back('{16'h1357, 8'hAB});
      run_op(1'b1, 1'b0, 20);
      e = exp_q.pop_front();
      n_chk++;
      if (!got_done || {d_err, d_ip, d_mc, d_tc} !== {e.err, e.ip, e.mc, e.tc}) $display("FAIL rst_after_op: got done=%0d %h want %h", got_done, {d_err, d_ip, d_mc, d_tc}, {e.err, e.ip, e.mc, e.tc});
      else n_pass++;
      w = exp_wr.pop_front();
      n_chk++;
      if (act_wr.size() != 1 || act_wr[0] != w) $display("FAIL rst_after_write: got %0d writes want 1 of %h/%h", act_wr.size(), w.addr, w.data);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      exp_t e; wr_t w;
      @(negedge clk);
      sel = 1'b0; opcode = 8'h70; reg_hl = 16'h8000; reg_src = 8'h11; ip_in = 16'h2000;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back('{1'b0, 16'h2001, 3'd2, 6'd7});
         exp_wr.push_back('{16'h8000, 8'h11});
      end
      run_op(1'b1, 1'b1, 20);          // start stays high
      e = exp_q.pop_front();
      n_chk++;
      if (!got_done || done_cyc != 4 || {d_err, d_ip, d_mc, d_tc} !== {e.err, e.ip, e.mc, e.tc}) $display("FAIL b2b_first: got done=%0d at %0d %h want at 4 %h", got_done, done_cyc, {d_err, d_ip, d_mc, d_tc}, {e.err, e.ip, e.mc, e.tc});
      else n_pass++;
      w = exp_wr.pop_front();
      n_chk++;
      if (act_wr.size() != 1 || act_wr[0] != w) $display("FAIL b2b_one_write: got %0d writes want 1 of %h/%h", act_wr.size(), w.addr, w.data);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (m_busy !== 1'b0 || m_mreq !== 1'b0) $display("FAIL b2b_idle_gap: got busy=%b mreq=%b want 0 0", m_busy, m_mreq);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (m_busy !== 1'b1 || m_mreq !== 1'b1) $display("FAIL b2b_restart: got busy=%b mreq=%b want 1 1", m_busy, m_mreq);
      else n_pass++;
      start = 1'b0;
      run_op(1'b0, 1'b0, 20);
      e = exp_q.pop_front();
      n_chk++;
      if (!got_done || {d_err, d_ip, d_mc, d_tc} !== {e.err, e.ip, e.mc, e.tc}) $display("FAIL b2b_second: got done=%0d %h want %h", got_done, {d_err, d_ip, d_mc, d_tc}, {e.err, e.ip, e.mc, e.tc});
      else n_pass++;
      w = exp_wr.pop_front();
      n_chk++;
      if (act_wr.size() != 1 || act_wr[0] != w) $display("FAIL b2b_second_write: got %0d writes want 1 of %h/%h", act_wr.size(), w.addr, w.data);
      else n_pass++;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; sel = 1'b0; bus_wait = 1'b0; bus_rdata = 8'h00;
      opcode = 8'h00; ip_in = '0; reg_a = '0; reg_bc = '0; reg_de = '0; reg_hl = '0; reg_src = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_store_de();
      test_store_nn();
      test_wait_states();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/z80_store_seq.md
# z80_store_seq

Multi-cycle sequencer that executes the Z80 register-to-memory store family after the opcode fetch: LD (BC),A, LD (DE),A, LD (HL),r and, optionally, LD (nn),A. It sits between the decoder and the external bus interface. It does three things:
- drives the operand-read and memory-write machine cycles with Z80 T-state timing, including wait states;
- reports the updated IP;
- reports the M-cycle and T-state counts, which the z80fi checker compares against the instruction specs.

## Interface
Parameters:
- WAIT_STATES, 0: fixed Tw states inserted after T2 of every memory cycle this block drives (0..7).
- ENABLE_NN, 1: when 1, opcode 0x32 LD (nn),A is supported; when 0, it is rejected as illegal.

Ports:
- clk  in  1  core clock; one clock equals one T-state.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; the opcode has already been fetched during M1.
- opcode  in  8  fetched opcode, sampled when start is accepted.
- ip_in  in  16  address of the opcode byte.
- reg_a  in  8  A register.
- reg_bc, reg_de, reg_hl  in  16  register pairs.
- reg_src  in  8  source register r for the 0x70-0x77 opcodes, already selected by the core.
- bus_rdata  in  8  memory read data.
- bus_wait  in  1  external wait request, active-high.
- busy  out  1  high in every state except IDLE.
- bus_addr  out  16  memory address.
- bus_wdata  out  8  write data.
- bus_mreq, bus_rd, bus_wr  out  1 each  bus strobes.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: illegal opcode.
- ip_out  out  16  next IP; valid with done.
- mcycles  out  3  M-cycle count including M1; valid with done.
- tcycles  out  6  T-state count including the 4 T-states of M1; saturates at 63; valid with done.

## Operation
States: IDLE, RD_LO, RD_HI, WR, DONE. Each memory state steps through sub-phases T1, T2, Tw*, T3.

IDLE:
- start is accepted only in IDLE; start while busy=1 (including in DONE) is ignored.
- On accept, opcode, ip_in, reg_a, reg_bc, reg_de, reg_hl and reg_src are latched. Later changes on these inputs have no effect.

Decode and target state:
- 0x02 gives address BC and data A; go to WR.
- 0x12 gives address DE and data A; go to WR.
- 0x70-0x75 and 0x77 give address HL and data reg_src; go to WR.
- 0x32 with ENABLE_NN=1 goes to RD_LO.
- Anything else, including 0x76 (HALT) and 0x32 with ENABLE_NN=0, goes to DONE with err=1. No bus cycle is issued.

RD_LO / RD_HI:
- bus_addr is ip+1 in RD_LO and ip+2 in RD_HI.
- bus_mreq=1 and bus_rd=1 for all T-states of the cycle.
- bus_rdata is captured on the clock edge that ends T3: the low byte in RD_LO, the high byte in RD_HI.
- RD_LO is followed by RD_HI; RD_HI is followed by WR, with address {hi,lo} and data A.

WR:
- bus_addr and bus_wdata are stable from T1 through T3.
- bus_mreq=1 from T1 through T3; bus_wr=1 from T2 through T3.
- After T3, go to DONE.

Wait states:
- After T2, a Tw is inserted while fewer than WAIT_STATES fixed Tw have elapsed, or while bus_wait=1.
- bus_wait is sampled in T2 and in each Tw.
- Strobes, address and data hold through every Tw.

DONE:
- done=1 for one cycle, then return to IDLE.
- On success: ip_out = ip+1 (1-byte opcodes) or ip+3 (0x32), with 16-bit wrap-around.
- On err: ip_out = ip+1, mcycles=1, tcycles=4.

Counts:
- mcycles = 1 + number of memory cycles executed.
- tcycles = 4 + 3 per memory cycle + every Tw. The sum saturates at 63, never wraps.

## Timing
- Reset values: busy, done, err, bus_mreq, bus_rd and bus_wr are 0; bus_addr, bus_wdata, ip_out, mcycles and tcycles are 0. State is IDLE.
- Reset asserted mid-operation clears the strobes asynchronously. No done is produced, and no partial write is retried.
- All outputs are registered. The first T1 occurs the cycle after start is accepted.
- Latency from the start cycle to done, with w = total Tw in a memory cycle:
  - 1-byte store: 1 + (3+w) + 1 cycles.
  - 0x32: 1 + 3×(3+w) + 1 cycles, assuming equal w in each cycle.
  - Illegal opcode: done in the second cycle after start (one cycle of DONE entry).
- Strobes are never asserted outside RD_LO, RD_HI and WR. bus_rd and bus_wr are never both 1.
- Back-to-back: start is next accepted in the IDLE cycle following DONE.

## Test plan
- Opcode 0x12 with DE=0x4000, A=0x5A, WAIT_STATES=0, bus_wait=0: one write of 0x5A to 0x4000. bus_wr is high for 2 cycles. done shows ip_out=ip_in+1, mcycles=2, tcycles=7.
- Opcode 0x32, ip_in=0xFFFE, memory bytes 0x34 then 0x12, A=0xC3: reads come from 0xFFFF and then 0x0000 (wrap-around). One write of 0xC3 to 0x1234. done shows ip_out=0x0001, mcycles=4, tcycles=13.
- Opcode 0x02 with WAIT_STATES=2 and bus_wait high for 3 extra cycles: tcycles=4+3+5=12. Address, data and strobes stay stable throughout all Tw.
- Opcodes 0x76, 0x00, and 0x32 with ENABLE_NN=0: done with err=1, mcycles=1, tcycles=4, and no strobe asserted.
- reset pulsed during T2 of a WR cycle: strobes are 0 immediately, there is no done, and the block is in IDLE with busy=0. A following 0x77 completes normally.
- start held high through an entire 0x70 operation with HL=0x8000 and reg_src=0x11: exactly one write of 0x11 to 0x8000 happens. A second operation begins only in the IDLE cycle after DONE.
